// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - two-requester round-robin config register writer with shadowed PWM duty
module cfg_write_arbiter #(
    parameter int unsigned DUTY_SHADOW = 1,
    parameter logic [7:0]  RST_DUTY    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       period_end,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       duty_pending,
    output logic       wr_err
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [6:0] ADDR_DUTY = 7'h04;

    state_t     state_q;
    logic       gnt_q;
    logic       last_grant_q;
    logic [6:0] addr_q;
    logic [7:0] data_q;
    logic [1:0] ready_q;
    logic       err_q;
    logic [7:0] out_lo_q;
    logic [7:0] out_hi_q;
    logic [7:0] pwm_lo_q;
    logic [7:0] pwm_hi_q;
    logic [7:0] shadow_q;
    logic [7:0] duty_q;

    logic       gnt_d;
    logic [6:0] addr_d;
    logic [7:0] data_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt_d = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_d = ~last_grant_q;
        end
        addr_d = gnt_d ? req1_addr : req0_addr;
        data_d = gnt_d ? req1_data : req0_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= 7'h00;
            data_q       <= 8'h00;
            ready_q      <= 2'b00;
            err_q        <= 1'b0;
            out_lo_q     <= 8'h00;
            out_hi_q     <= 8'h00;
            pwm_lo_q     <= 8'h00;
            pwm_hi_q     <= 8'h00;
            shadow_q     <= RST_DUTY;
            duty_q       <= RST_DUTY;
        end else begin
            ready_q <= 2'b00;
            err_q   <= 1'b0;
            if (DUTY_SHADOW != 0 && period_end) begin
                duty_q <= shadow_q;
            end
            case (state_q)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        state_q <= GRANT;
                        gnt_q   <= gnt_d;
                        addr_q  <= addr_d;
                        data_q  <= data_d;
                        ready_q <= gnt_d ? 2'b10 : 2'b01;
                        err_q   <= addr_d > ADDR_DUTY;
                    end
                end
                GRANT: begin
                    state_q      <= IDLE;
                    last_grant_q <= gnt_q;
                    // A duty write coinciding with period_end goes straight to the active register.
                    case (addr_q)
                        7'h00: out_lo_q <= data_q;
                        7'h01: out_hi_q <= data_q;
                        7'h02: pwm_lo_q <= data_q;
                        7'h03: pwm_hi_q <= data_q;
                        ADDR_DUTY: begin
                            shadow_q <= data_q;
                            if (DUTY_SHADOW == 0 || period_end) begin
                                duty_q <= data_q;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The completion pulse is masked while reset is held so an aborted grant never signals done.
    assign req0_ready      = ready_q[0] & rst_n;
    assign req1_ready      = ready_q[1] & rst_n;
    assign wr_err          = err_q & rst_n;
    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign duty_pending    = (DUTY_SHADOW != 0) && (shadow_q != duty_q);
endmodule

// File: doc/cfg_write_arbiter.md
CFG_WRITE_ARBITER -- requirements
Module: cfg_write_arbiter

Interface
REQ-001 SHALL have parameter DUTY_SHADOW, default 1: 1 = duty writes are buffered and applied at PWM period end; 0 = duty writes apply immediately.
REQ-002 SHALL have parameter RST_DUTY, default 8'h00: reset value of the shadow and active duty registers.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1 each  write request; req0 = SPI decoder, req1 = local sequencer.
REQ-006 SHALL have ports req0_addr / req1_addr  input  7 each  target register address.
REQ-007 SHALL have ports req0_data / req1_data  input  8 each  write data.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have port period_end  input  1  one-cycle pulse marking the PWM period boundary.
REQ-010 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8  output  8 each  config registers at addresses 0x00-0x03.
REQ-011 SHALL have port pwm_duty_cycle  output  8  active duty register at address 0x04.
REQ-012 SHALL have port duty_pending  output  1  high while the shadow duty differs from the active duty.
REQ-013 SHALL have port wr_err  output  1  one-cycle pulse on a write to an unmapped address.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-015 IDLE, no valid: SHALL remain in IDLE.
REQ-016 IDLE, exactly one valid: SHALL grant that requester, capture its addr/data, and enter GRANT.
REQ-017 IDLE, both valid: SHALL grant the requester other than last_grant (round-robin), capture that requester's addr/data, and enter GRANT.
REQ-018 GRANT: SHALL assert only the granted reqN_ready for exactly one cycle, perform the write, set last_grant to the granted index, and return to IDLE.
REQ-019 Latency: valid sampled in IDLE at cycle N -> ready high in N+1 -> register output updated in N+2; peak throughput is one write per 2 cycles.
REQ-020 Requesters SHALL hold valid/addr/data until ready; if valid drops after capture, the captured write SHALL still complete and ready SHALL still pulse.
REQ-021 Decode: 0x00-0x03 SHALL write the matching en_reg_* output.
REQ-022 Decode: 0x04 with DUTY_SHADOW=1 SHALL write the duty shadow only; with DUTY_SHADOW=0 it SHALL write pwm_duty_cycle directly.
REQ-023 Decode: 0x05-0x7F SHALL change no register and SHALL pulse wr_err in the same cycle as ready.
REQ-024 On period_end with DUTY_SHADOW=1, pwm_duty_cycle SHALL load the shadow on the next clock edge.
REQ-025 If a 0x04 write and period_end occur in the same GRANT cycle, shadow and pwm_duty_cycle SHALL both take the new data.
REQ-026 duty_pending SHALL be combinational (shadow != pwm_duty_cycle); it SHALL be constant 0 when DUTY_SHADOW=0.
REQ-027 period_end SHALL have no effect on FSM state or arbitration.

Reset
REQ-028 When rst_n is low at a clock edge: FSM -> IDLE; all en_reg_* -> 8'h00; shadow and pwm_duty_cycle -> RST_DUTY; last_grant -> 1, so req0 wins the first tie; ready and wr_err -> 0.
REQ-029 Reset during GRANT SHALL abort the write: no ready pulse, no register change.
REQ-030 The first request SHALL be sampled in the first IDLE cycle after rst_n returns high.

Verification
REQ-031 Single write: req0 addr 0x02 data 0xA5 -> req0_ready in N+1; en_reg_pwm_7_0 = 0xA5 in N+2; other outputs unchanged.
REQ-032 Tie after reset: both valid (req0 0x00/0x11, req1 0x01/0x22), held -> req0 served first, then req1; en_reg_out_7_0 = 0x11, en_reg_out_15_8 = 0x22.
REQ-033 Fairness: both held valid for 8 writes -> grants strictly alternate 0,1,0,1,...; neither requester gets 2 consecutive grants.
REQ-034 Shadow duty: write 0x04 = 0x80 -> pwm_duty_cycle holds 0x00 and duty_pending = 1 until period_end; next edge -> 0x80 and duty_pending = 0.
REQ-035 Bad address: req1 addr 0x05 data 0xFF -> req1_ready and wr_err pulse together; all outputs unchanged.
REQ-036 Reset mid-GRANT: rst_n low in the GRANT cycle of a 0x03/0x3C write -> no ready pulse; en_reg_pwm_15_8 = 0x00.
